// File: rtl/bist_pkg.sv
// Shared types and the shift-with-parity-feedback step used by both the
// pattern LFSR and the response MISR of the BIST harness.
package bist_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DONE
    } st_e;

    // Shift left by one, feeding the parity of the masked bits into bit 0.
    // Callers zero-extend into MAX_W and truncate the result to their width.
    function automatic logic [MAX_W-1:0] next_lfsr(input logic [MAX_W-1:0] value,
                                                   input logic [MAX_W-1:0] mask);
        return (value << 1) | MAX_W'(^(value & mask));
    endfunction

endpackage

// File: rtl/bist_seq_harness_if.sv
// Harness <-> environment bundle: start/done run handshake, pattern out, response in.
// Optional pass flag exists only when BIST_GOLDEN_CMP_EN is defined.
interface bist_seq_harness_if #(
    parameter int PI_W = 18,
    parameter int PO_W = 19
);
    // Handshake: start is a level sampled only in IDLE/DONE; one run follows
    // (busy high for INIT+RUN), then done stays high with a stable signature
    // until the next start is accepted. start during a run is ignored.
    logic            start;
    logic [PI_W-1:0] pat_out;
    logic            cut_clr;
    logic [PO_W-1:0] resp_in;
    logic            busy;
    logic            done;
    logic [PO_W-1:0] signature;
`ifdef BIST_GOLDEN_CMP_EN
    logic            pass;
`endif

    modport master (
        output start, resp_in,
        input  pat_out, cut_clr, busy, done, signature
`ifdef BIST_GOLDEN_CMP_EN
        , input pass
`endif
    );

    modport slave (
        input  start, resp_in,
        output pat_out, cut_clr, busy, done, signature
`ifdef BIST_GOLDEN_CMP_EN
        , output pass
`endif
    );

endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift with polynomial feedback, XOR in d.
module bist_misr
    import bist_pkg::*;
#(
    parameter int           W    = 19,
    parameter logic [W-1:0] POLY = 19'h40023
) (
    input  logic         CK,
    input  logic         RSTN,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= W'(next_lfsr(MAX_W'(q), MAX_W'(POLY))) ^ d;
        end
    end

endmodule

// File: rtl/bist_seq_harness.sv
// BIST harness for a sequential benchmark core: LFSR patterns, one-cycle CUT clear,
// MISR compaction over NPAT patterns. BIST_GOLDEN_CMP_EN adds GOLDEN and a pass flag.
module bist_seq_harness
    import bist_pkg::*;
#(
    parameter int              PI_W      = 18,
    parameter int              PO_W      = 19,
    parameter int              NPAT      = 256,
    parameter logic [PI_W-1:0] LFSR_TAPS = 18'h24000,
    parameter logic [PI_W-1:0] LFSR_SEED = 18'h00001,
    parameter logic [PO_W-1:0] MISR_POLY = 19'h40023
`ifdef BIST_GOLDEN_CMP_EN
    , parameter logic [PO_W-1:0] GOLDEN  = '0
`endif
) (
    input  logic              CK,
    input  logic              RSTN,
    bist_seq_harness_if.slave bus,
    output st_e               dbg_state
);

    localparam int CNT_W = (NPAT > 1) ? $clog2(NPAT) : 1;

    if (LFSR_SEED == '0) begin : g_zero_seed
        $error("LFSR_SEED must be nonzero: an all-zero LFSR never leaves zero");
    end
    if (PI_W > MAX_W || PO_W > MAX_W) begin : g_too_wide
        $error("PI_W and PO_W must not exceed bist_pkg::MAX_W");
    end

    st_e             state;
    logic [PI_W-1:0] lfsr;
    logic [CNT_W-1:0] cnt;
    logic            cut_clr_q;
    logic            busy_q;
    logic            done_q;
    logic [PO_W-1:0] misr_q;
    logic            last_pat;

    assign last_pat = (cnt == CNT_W'(NPAT - 1));

    bist_misr #(
        .W    (PO_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .CK   (CK),
        .RSTN (RSTN),
        .clr  (state == ST_INIT),
        .en   (state == ST_RUN),
        .d    (bus.resp_in),
        .q    (misr_q)
    );

`ifdef BIST_GOLDEN_CMP_EN
    logic            pass_q;
    logic [PO_W-1:0] misr_nx;

    // Same value the MISR takes on this edge, so the verdict lands with done.
    assign misr_nx = PO_W'(next_lfsr(MAX_W'(misr_q), MAX_W'(MISR_POLY))) ^ bus.resp_in;
    assign bus.pass = pass_q;
`endif

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= ST_IDLE;
            lfsr      <= LFSR_SEED;
            cnt       <= '0;
            cut_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BIST_GOLDEN_CMP_EN
            pass_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state     <= ST_INIT;
                        cut_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
`ifdef BIST_GOLDEN_CMP_EN
                        pass_q    <= 1'b0;
`endif
                    end
                end
                ST_INIT: begin
                    state     <= ST_RUN;
                    cut_clr_q <= 1'b0;
                    lfsr      <= LFSR_SEED;
                    cnt       <= '0;
                end
                ST_RUN: begin
                    lfsr <= PI_W'(next_lfsr(MAX_W'(lfsr), MAX_W'(LFSR_TAPS)));
                    if (last_pat) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`ifdef BIST_GOLDEN_CMP_EN
                        pass_q <= (misr_nx == GOLDEN);
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pat_out   = lfsr;
    assign bus.cut_clr   = cut_clr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = misr_q;
    assign dbg_state     = state;

endmodule
